hmmm_mem_responder: RTL

Memory-side responder for the 8-bit two-phase processor bus (Adr, MemWrite, MemData). Holds the unified 256×15 instruction/data memory and serves reads combinationally and writes at cycle end. Also contains a program-load port and sequencer that fills memory while holding the processor in reset, then releases it. Sits beside the processor at top level and owns the other end of the MemData tristate bus.

---
 rtl/hmmm_mem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hmmm_mem_responder.sv
// hmmm_mem_responder: unified 256x15 memory on the two-phase processor bus, plus a
// program loader that holds the CPU in reset until the image is in. Optional macro: MEM_WRITE_PROTECT_EN.
module hmmm_mem_responder #(
    parameter int            DEPTH      = 256,
    parameter int            AW         = 8,
    parameter int            DW         = 15,
    parameter logic [AW-1:0] PROT_LIMIT = 8'd16,
    parameter int            HOLD_CYC   = 2
) (
    input  logic          ph1,
    input  logic          ph2,
    input  logic          reset,
    input  logic [AW-1:0] Adr,
    input  logic          MemWrite,
    inout  wire  [DW-1:0] MemData,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_word,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          cpu_reset,
    output logic          running,
    output logic          prot_fault
);

`ifdef MEM_WRITE_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    localparam int             HCW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYC - 1);
    localparam logic [AW-1:0]  LAST_ADR  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD,
        HOLD,
        RUN
    } state_t;

    logic [DW-1:0] mem [DEPTH];

    state_t        state_p0, state_p1, state_nxt;
    logic [AW-1:0] ptr_p0, ptr_p1, ptr_nxt;
    logic [HCW-1:0] hcnt_p0, hcnt_p1, hcnt_nxt;
    logic          fault_p0, fault_p1;

    logic          we_p0;
    logic [AW-1:0] waddr_p0;
    logic [DW-1:0] wdata_p0;

    logic          load_we;
    logic          bus_we;
    logic          fault_set;
    logic          prot_hit;

    assign prot_hit = (Adr < PROT_LIMIT);

    // Reads are combinational so the processor can mux the instruction in the same cycle.
    assign MemData = MemWrite ? {DW{1'bz}} : mem[Adr];

    always_comb begin
        state_nxt = state_p1;
        ptr_nxt   = ptr_p1;
        hcnt_nxt  = hcnt_p1;
        ld_ready  = 1'b0;
        cpu_reset = 1'b1;
        running   = 1'b0;
        load_we   = 1'b0;
        bus_we    = 1'b0;
        fault_set = 1'b0;
        if (!reset) begin
            case (state_p1)
                LOAD: begin
                    ld_ready = 1'b1;
                    if (ld_valid) begin
                        load_we = 1'b1;
                        ptr_nxt = ptr_p1 + 1'b1;
                        if (ld_last || ptr_p1 == LAST_ADR) begin
                            state_nxt = HOLD;
                            hcnt_nxt  = '0;
                        end
                    end
                end
                HOLD: begin
                    if (hcnt_p1 == HOLD_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        hcnt_nxt = hcnt_p1 + 1'b1;
                    end
                end
                RUN: begin
                    cpu_reset = 1'b0;
                    running   = 1'b1;
                    if (MemWrite) begin
                        if (PROT_EN && prot_hit) begin
                            fault_set = 1'b1;
                        end else begin
                            bus_we = 1'b1;
                        end
                    end
                end
                default: state_nxt = LOAD;
            endcase
        end
    end

    // ph2: capture next state and the pending memory write
    always_ff @(posedge ph2) begin
        if (reset) begin
            state_p0 <= LOAD;
            ptr_p0   <= '0;
            hcnt_p0  <= '0;
            fault_p0 <= 1'b0;
            we_p0    <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            ptr_p0   <= ptr_nxt;
            hcnt_p0  <= hcnt_nxt;
            fault_p0 <= fault_p1 | fault_set;
            we_p0    <= load_we | bus_we;
        end
    end

    always_ff @(posedge ph2) begin
        waddr_p0 <= load_we ? ptr_p1 : Adr;
        wdata_p0 <= load_we ? ld_word : {{(DW-8){1'b0}}, MemData[7:0]};
    end

    // ph1: transfer to visible state; memory write commits at cycle end
    always_ff @(posedge ph1) begin
        state_p1 <= state_p0;
        ptr_p1   <= ptr_p0;
        hcnt_p1  <= hcnt_p0;
        fault_p1 <= fault_p0;
    end

    always_ff @(posedge ph1) begin
        if (we_p0) begin
            mem[waddr_p0] <= wdata_p0;
        end
    end

    assign prot_fault = PROT_EN & fault_p1;

endmodule
